rc4_stream: RTL and testbench
=============================

# rc4_stream

Parametrised RC4 cipher engine and successor to `key_gene`. It accepts a variable-length key over a valid/ready stream and runs the key-scheduling algorithm (KSA) over a 2^N-entry state array. It can optionally discard the first DROP keystream words (RC4-drop), then XORs a data stream with the keystream. It sits between the key/config front end and the data path; the same block both encodes and decodes.

## Interface
Parameters:
- N, 8: word width; the S-box has 2^N entries of N bits.
- KEY_MAX, 16: maximum key length in words.
- DROP, 0: keystream words discarded after KSA, before first output.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a new key session (one-cycle pulse).
- key_len  in  $clog2(KEY_MAX+1)  key length, sampled on accepted start.
- key_valid  in  1  key word valid.
- key_data  in  N  key word.
- key_ready  out  1  high in LOAD.
- din_valid  in  1  data word valid.
- din  in  N  plaintext or ciphertext word.
- din_ready  out  1  equals RUN && (!dout_valid || dout_ready).
- dout_valid  out  1  output word valid.
- dout  out  N  din XOR keystream.
- dout_ready  in  1  downstream accepts dout.
- busy  out  1  high in LOAD, KSA and DROP.
- ks_ready  out  1  high in RUN.
- err  out  1  one-cycle pulse when start is rejected.

## Operation
States (rc4_pkg::state_t): IDLE, LOAD, KSA, DROP, RUN.

- **IDLE:**
  - start with 1 ≤ key_len ≤ KEY_MAX: S[k]=k for all k; i=j=0; key count=0; go to LOAD.
  - Any other key_len: pulse err, stay in IDLE.
- **LOAD:**
  - Each key_valid && key_ready stores key_data into K[count] and increments count.
  - After key_len words, go to KSA with i=0.
- **KSA:** one step per cycle.
  - j = j + S[i] + K[i mod key_len].
  - Swap S[i] and S[j]; i++.
  - After 2^N steps, set i=j=0 and go to DROP if DROP>0, else RUN.
- **DROP:** one PRGA step per cycle with no output. After DROP steps, go to RUN.
- **PRGA step** (used in DROP and RUN):
  - i = i+1; j = j+S[i].
  - Swap S[i] and S[j].
  - Keystream word = S[S[i]+S[j]], using post-swap values.
- **RUN:**
  - Each din_valid && din_ready performs one PRGA step and registers dout = din ^ keystream with dout_valid=1.
  - dout_valid clears on dout_ready when no new word is accepted in the same cycle.
  - No step occurs without an accepted din word.
- **Restart and ignored start:**
  - start in RUN with a legal key_len restarts as from IDLE; a pending dout_valid is dropped.
  - start in LOAD, KSA or DROP is ignored.
- **Arithmetic:**
  - All index and j arithmetic is modulo 2^N; carries are discarded.
  - The key index wraps at key_len, not at KEY_MAX.
- **Reset:** a synchronous rst, including mid-LOAD, mid-KSA or mid-RUN, returns the block to IDLE. The S-box content is don't-care.

## Timing
- Reset values:
  - state=IDLE; i=j=0.
  - key_ready=0, din_ready=0, dout_valid=0, dout=0.
  - busy=0, ks_ready=0, err=0.
- Accepted start at cycle t: key_ready=1 and busy=1 from t+1.
- Last key word accepted at cycle u: KSA runs for cycles u+1 to u+2^N.
- DROP runs for the next DROP cycles.
- ks_ready rises at cycle u+2^N+DROP+1.
- Data latency: din accepted at cycle r gives dout_valid at r+1.
- Throughput: one word per cycle when dout_ready stays high.
- Back-pressure: dout_valid && !dout_ready forces din_ready=0; dout and dout_valid hold.
- err: single cycle, at t+1 after the rejected start.

## Structure
- Shared package rc4_pkg holds:
  - state_t.
  - A function for the PRGA next-index computation.
  - Default-parameter constants.
- Sub-module rc4_sbox:
  - 2^N×N register array.
  - Synchronous identity init.
  - Combinational read ports at i, j and S[i]+S[j] (mod 2^N).
  - Single-cycle swap write.
- The rc4_stream top holds the FSM, key register file, i/j registers and the output register.

## Test plan
- Key "Key" (3 words), DROP=0, din="Plaintext" → dout = BB F3 16 E8 D9 40 AF 0A D3.
- Key "Wiki", din="pedia" → dout = 10 21 BF 04 20. Then restart with key "Secret", din="Attack at dawn" → 45 A0 1F 64 5F C3 5B 38 35 52 54 4B 9B F5.
- Back-pressure: key "Key", din all zeros, dout_ready toggling 1/0 → keystream EB 9F 77 81 B7 34 CA 72 A7 19 in order, no word lost or duplicated.
- key_len=0 and key_len=KEY_MAX+1 → err pulse, state stays IDLE, key_ready=0.
- DROP=3, key "Key", din zeros → first dout = 81 B7 34; ks_ready rises 3 cycles later than with DROP=0.
- rst asserted mid-KSA, then a new "Key" session → output identical to the first scenario.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 stream engine and its S-box.
package rc4_pkg;

  localparam int unsigned N_DEF       = 8;
  localparam int unsigned KEY_MAX_DEF = 16;
  localparam int unsigned DROP_DEF    = 0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    KSA,
    DROP,
    RUN
  } state_t;

  // PRGA index advance: i+1 wrapped to an n-bit index space.
  function automatic logic [31:0] prga_next(input logic [31:0] idx, input int unsigned n);
    logic [31:0] mask;
    mask = (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
    return (idx + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/rc4_sbox.sv
// 2^N x N permutation array: identity init, three combinational reads, one swap per cycle.
module rc4_sbox
  import rc4_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic         clk,
  input  logic         init,
  input  logic         swap,
  input  logic [N-1:0] addr_i,
  input  logic [N-1:0] addr_j,
  output logic [N-1:0] s_i,
  output logic [N-1:0] s_j,
  output logic [N-1:0] s_t
);

  localparam int unsigned DEPTH = 1 << N;

  logic [N-1:0] mem [DEPTH];
  logic [N-1:0] addr_t;

  assign s_i    = mem[addr_i];
  assign s_j    = mem[addr_j];
  assign addr_t = s_i + s_j;
  assign s_t    = mem[addr_t];

  // When addr_i == addr_j both branches would write the same value, so the priority is harmless.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (init) begin
        mem[N'(k)] <= N'(k);
      end else if (swap) begin
        if (N'(k) == addr_i) begin
          mem[N'(k)] <= s_j;
        end else if (N'(k) == addr_j) begin
          mem[N'(k)] <= s_i;
        end
      end
    end
  end

endmodule

// File: rtl/rc4_stream.sv
// RC4 engine: key load, KSA, optional keystream drop, then din XOR keystream with valid/ready.
module rc4_stream
  import rc4_pkg::*;
#(
  parameter int unsigned N       = N_DEF,
  parameter int unsigned KEY_MAX = KEY_MAX_DEF,
  parameter int unsigned DROP    = DROP_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(KEY_MAX+1)-1:0] key_len,
  input  logic                         key_valid,
  input  logic [N-1:0]                 key_data,
  output logic                         key_ready,
  input  logic                         din_valid,
  input  logic [N-1:0]                 din,
  output logic                         din_ready,
  output logic                         dout_valid,
  output logic [N-1:0]                 dout,
  input  logic                         dout_ready,
  output logic                         busy,
  output logic                         ks_ready,
  output logic                         err
);

  localparam int unsigned KLW = $clog2(KEY_MAX + 1);
  localparam int unsigned KIW = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;
  localparam int unsigned DW  = (DROP > 1) ? $clog2(DROP) : 1;

  state_t         state;
  logic [N-1:0]   i, j;
  logic [N-1:0]   key_mem [KEY_MAX];
  logic [KLW-1:0] klen;
  logic [KIW-1:0] kcnt;
  logic [DW-1:0]  dcnt;
  logic           err_q;
  logic           dout_valid_q;
  logic [N-1:0]   dout_q;

  logic [31:0]    i_inc_w;
  logic           unused_hi;
  logic [N-1:0]   i_inc;
  logic           ksa_mode;
  logic [N-1:0]   addr_a, j_new, s_a, s_b, s_t, t_idx, ks;
  logic           legal, start_ok_state, restart, accept, sbox_swap, kwrap;

  assign i_inc_w   = prga_next(32'(i), N);
  assign i_inc     = i_inc_w[N-1:0];
  assign unused_hi = ^i_inc_w[31:N];

  assign ksa_mode = (state == KSA);
  assign addr_a   = ksa_mode ? i : i_inc;
  assign j_new    = ksa_mode ? (j + s_a + key_mem[kcnt]) : (j + s_a);
  assign kwrap    = (KLW'(kcnt) == klen - KLW'(1));

  // The S-box reads pre-swap contents; remap S[S[i]+S[j]] onto the post-swap view.
  assign t_idx = s_a + s_b;
  assign ks    = (t_idx == addr_a) ? s_b :
                 (t_idx == j_new)  ? s_a : s_t;

  assign legal          = (key_len != '0) && (key_len <= KLW'(KEY_MAX));
  assign start_ok_state = (state == IDLE) || (state == RUN);
  assign restart        = start && legal && start_ok_state;

  assign key_ready  = (state == LOAD);
  assign busy       = (state == LOAD) || (state == KSA) || (state == rc4_pkg::DROP);
  assign ks_ready   = (state == RUN);
  assign din_ready  = (state == RUN) && (!dout_valid_q || dout_ready);
  assign accept     = din_valid && din_ready;
  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign err        = err_q;

  assign sbox_swap = !restart &&
                     (ksa_mode || (state == rc4_pkg::DROP) || ((state == RUN) && accept));

  rc4_sbox #(.N(N)) u_sbox (
    .clk    (clk),
    .init   (restart),
    .swap   (sbox_swap),
    .addr_i (addr_a),
    .addr_j (j_new),
    .s_i    (s_a),
    .s_j    (s_b),
    .s_t    (s_t)
  );

  // State literal DROP is scoped explicitly: the DROP parameter shadows the imported name.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      i            <= '0;
      j            <= '0;
      klen         <= '0;
      kcnt         <= '0;
      dcnt         <= '0;
      err_q        <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
    end else begin
      err_q <= 1'b0;
      if (restart) begin
        state        <= LOAD;
        i            <= '0;
        j            <= '0;
        kcnt         <= '0;
        klen         <= key_len;
        dout_valid_q <= 1'b0;
      end else begin
        if (start && start_ok_state) begin
          err_q <= 1'b1;
        end
        case (state)
          LOAD: begin
            if (key_valid) begin
              key_mem[kcnt] <= key_data;
              if (kwrap) begin
                state <= KSA;
                kcnt  <= '0;
                i     <= '0;
              end else begin
                kcnt <= kcnt + KIW'(1);
              end
            end
          end
          KSA: begin
            j    <= j_new;
            i    <= i + N'(1);
            kcnt <= kwrap ? '0 : kcnt + KIW'(1);
            if (i == '1) begin
              i     <= '0;
              j     <= '0;
              dcnt  <= '0;
              state <= (DROP > 0) ? rc4_pkg::DROP : RUN;
            end
          end
          rc4_pkg::DROP: begin
            i    <= i_inc;
            j    <= j_new;
            dcnt <= dcnt + DW'(1);
            if (32'(dcnt) == DROP - 1) begin
              state <= RUN;
            end
          end
          RUN: begin
            if (accept) begin
              i            <= i_inc;
              j            <= j_new;
              dout_q       <= din ^ ks;
              dout_valid_q <= 1'b1;
            end else if (dout_ready) begin
              dout_valid_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rc4_stream.sv
// Scoreboard bench for rc4_stream: a DROP=0 and a DROP=3 instance share one stimulus stream.
module tb_rc4_stream;

  logic       clk = 1'b0;
  logic       rst, start, key_valid, din_valid, dout_ready;
  logic [4:0] key_len;
  logic [7:0] key_data, din;

  logic       key_ready0, din_ready0, dout_valid0, busy0, ks_ready0, err0;
  logic [7:0] dout0;
  logic       key_ready3, din_ready3, dout_valid3, busy3, ks_ready3, err3;
  logic [7:0] dout3;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];
  exp_t m0, m3;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int u_last   = 0;
  int rise0    = -1;
  int rise3    = -1;
  bit lat_chk  = 1'b0;
  bit chk3     = 1'b0;
  bit bp       = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rc4_stream #(.N(8), .KEY_MAX(16), .DROP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len),
    .key_valid(key_valid), .key_data(key_data), .key_ready(key_ready0),
    .din_valid(din_valid), .din(din), .din_ready(din_ready0),
    .dout_valid(dout_valid0), .dout(dout0), .dout_ready(dout_ready),
    .busy(busy0), .ks_ready(ks_ready0), .err(err0)
  );

  rc4_stream #(.N(8), .KEY_MAX(16), .DROP(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len),
    .key_valid(key_valid), .key_data(key_data), .key_ready(key_ready3),
    .din_valid(din_valid), .din(din), .din_ready(din_ready3),
    .dout_valid(dout_valid3), .dout(dout3), .dout_ready(dout_ready),
    .busy(busy3), .ks_ready(ks_ready3), .err(err3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && dout_valid0 && dout_ready) begin
      check_eq("dout0_expected", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) begin
        m0 = q0.pop_front();
        check_eq("dout0", 32'(dout0), 32'(m0.d));
        if (lat_chk) check_eq("dout0_latency", 32'(cyc), 32'(m0.c + 1));
      end
    end
    if (!rst && chk3 && dout_valid3 && dout_ready) begin
      check_eq("dout3_expected", 32'(q3.size() != 0), 32'd1);
      if (q3.size() != 0) begin
        m3 = q3.pop_front();
        check_eq("dout3", 32'(dout3), 32'(m3.d));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (bp) dout_ready = ~dout_ready;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bp = 1'b0;
    dout_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic session(input int len, input logic [127:0] key, input string tag);
    int w;
    start = 1'b1;
    key_len = 5'(len);
    tick();
    start = 1'b0;
    check_eq({tag, "_key_ready"}, 32'(key_ready0), 32'd1);
    check_eq({tag, "_busy"}, 32'(busy0), 32'd1);
    check_eq({tag, "_dout_valid_clr"}, 32'(dout_valid0), 32'd0);
    for (int k = 0; k < len; k++) begin
      key_valid = 1'b1;
      key_data = key[8*(len-1-k) +: 8];
      w = 0;
      while (!key_ready0 && w < 20) begin
        tick();
        w++;
      end
      u_last = cyc;
      tick();
    end
    key_valid = 1'b0;
    rise0 = -1;
    rise3 = -1;
  endtask

  task automatic wait_ks(input bit use3);
    int w;
    w = 0;
    while (w < 600) begin
      if (ks_ready0 && rise0 < 0) rise0 = cyc;
      if (ks_ready3 && rise3 < 0) rise3 = cyc;
      if (use3 ? ks_ready3 : ks_ready0) break;
      tick();
      w++;
    end
    check_eq("ks_ready_up", 32'(use3 ? ks_ready3 : ks_ready0), 32'd1);
  endtask

  task automatic send(input int n, input logic [127:0] dv, input logic [127:0] e0,
                      input logic [127:0] e3);
    int w;
    for (int k = 0; k < n; k++) begin
      din_valid = 1'b1;
      din = dv[8*(n-1-k) +: 8];
      w = 0;
      while (!din_ready0 && w < 50) begin
        tick();
        w++;
      end
      check_eq("din_ready_wait", 32'(din_ready0), 32'd1);
      q0.push_back('{d: e0[8*(n-1-k) +: 8], c: cyc});
      if (chk3) q3.push_back('{d: e3[8*(n-1-k) +: 8], c: cyc});
      tick();
    end
    din_valid = 1'b0;
    w = 0;
    while ((q0.size() != 0 || q3.size() != 0) && w < 100) begin
      tick();
      w++;
    end
    check_eq("drained", 32'(q0.size() + q3.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; key_len = '0; key_valid = 1'b0; key_data = '0;
    din_valid = 1'b0; din = '0; dout_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_eq("rst_key_ready", 32'(key_ready0), 32'd0);
    check_eq("rst_din_ready", 32'(din_ready0), 32'd0);
    check_eq("rst_dout_valid", 32'(dout_valid0), 32'd0);
    check_eq("rst_dout", 32'(dout0), 32'd0);
    check_eq("rst_busy", 32'(busy0), 32'd0);
    check_eq("rst_ks_ready", 32'(ks_ready0), 32'd0);
    check_eq("rst_err", 32'(err0), 32'd0);

    // Key / Plaintext
    lat_chk = 1'b1;
    session(3, "Key", "key1");
    wait_ks(1'b0);
    check_eq("ksa_latency", 32'(rise0 - u_last), 32'd257);
    send(9, "Plaintext", 72'hBBF316E8D940AF0AD3, '0);

    // Wiki / pedia, pending output, then restart with Secret
    do_reset();
    session(4, "Wiki", "wiki");
    wait_ks(1'b0);
    send(5, "pedia", 40'h1021BF0420, '0);
    dout_ready = 1'b0;
    din_valid = 1'b1;
    din = 8'h00;
    check_eq("pend_din_ready", 32'(din_ready0), 32'd1);
    tick();
    din_valid = 1'b0;
    check_eq("pend_valid", 32'(dout_valid0), 32'd1);
    check_eq("bp_din_ready", 32'(din_ready0), 32'd0);
    tick();
    check_eq("pend_hold", 32'(dout_valid0), 32'd1);
    session(6, "Secret", "secret");
    dout_ready = 1'b1;
    wait_ks(1'b0);
    send(14, "Attack at dawn", 112'h45A01F645FC35B383552544B9BF5, '0);

    // Back-pressure with toggling dout_ready
    do_reset();
    lat_chk = 1'b0;
    session(3, "Key", "bp");
    wait_ks(1'b0);
    bp = 1'b1;
    send(10, 80'h0, 80'hEB9F7781B734CA72A719, '0);
    bp = 1'b0;
    dout_ready = 1'b1;

    // Illegal key lengths
    do_reset();
    for (int n = 0; n < 2; n++) begin
      start = 1'b1;
      key_len = (n == 0) ? 5'd0 : 5'd17;
      tick();
      start = 1'b0;
      check_eq("err_pulse", 32'(err0), 32'd1);
      check_eq("err_key_ready", 32'(key_ready0), 32'd0);
      check_eq("err_busy", 32'(busy0), 32'd0);
      tick();
      check_eq("err_clear", 32'(err0), 32'd0);
      check_eq("err_idle", 32'(busy0 | ks_ready0), 32'd0);
    end

    // DROP=3 against DROP=0
    do_reset();
    lat_chk = 1'b1;
    chk3 = 1'b1;
    session(3, "Key", "drop");
    wait_ks(1'b1);
    check_eq("rise_drop0", 32'(rise0 - u_last), 32'd257);
    check_eq("rise_drop3", 32'(rise3 - u_last), 32'd260);
    send(6, 48'h0, 48'hEB9F7781B734, 48'h81B734CA72A7);
    chk3 = 1'b0;

    // Reset in the middle of KSA, then a fresh session
    do_reset();
    session(3, "Key", "midksa");
    repeat (100) tick();
    check_eq("midksa_busy", 32'(busy0), 32'd1);
    check_eq("midksa_ks", 32'(ks_ready0), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midksa_rst_busy", 32'(busy0), 32'd0);
    check_eq("midksa_rst_key_ready", 32'(key_ready0), 32'd0);
    check_eq("midksa_rst_dv", 32'(dout_valid0), 32'd0);
    session(3, "Key", "key2");
    wait_ks(1'b0);
    send(9, "Plaintext", 72'hBBF316E8D940AF0AD3, '0);

    check_eq("sb_empty", 32'(q0.size() + q3.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
